// File: rtl/pcie_phy_pkg.sv
// Shared PCIe PHY types: ordered-set container, training-sequence identifiers,
// special symbols and the TS receive parser state encoding.
package pcie_phy_pkg;

  localparam int TSOS_LEN = 16;

  // Symbol n of an ordered set lives at bits [8n+7:8n]
  typedef logic [TSOS_LEN-1:0][7:0] pcie_tsos_t;

  typedef enum logic [7:0] {
    TS1 = 8'h4A,
    TS2 = 8'h45
  } train_seq_e;

  typedef enum logic [7:0] {
    COM = 8'hBC,
    PAD = 8'hF7
  } phy_layer_special_symbols_e;

  typedef enum logic {
    HUNT    = 1'b0,
    CAPTURE = 1'b1
  } tsos_rx_state_e;

endpackage

// File: rtl/pcie_tsos_rx.sv
// Per-lane TS1/TS2 receive parser: captures and validates 16-symbol training
// ordered sets and counts consecutive identical TSs for the LTSSM.
module pcie_tsos_rx
  import pcie_phy_pkg::*;
#(
  parameter int CNT_W      = 4,
  parameter bit MATCH_NFTS = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       s_axis_tdata,
  input  logic             s_axis_tuser,
  input  logic             s_axis_tvalid,
  output logic             s_axis_tready,
  input  logic             clear_count,
  output logic             ts_valid,
  output logic             ts_type,
  output pcie_tsos_t       ts_data,
  output logic [CNT_W-1:0] ts_consec_count,
  output logic             ts_error
);

  localparam int IDX_W = $clog2(TSOS_LEN);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TSOS_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  tsos_rx_state_e           r_state;
  tsos_rx_state_e           w_next_state;
  logic [IDX_W-1:0]         r_idx;
  logic [IDX_W-1:0]         w_next_idx;
  logic [TSOS_LEN-2:0][7:0] r_buf;
  logic                     r_ts_valid;
  logic                     r_ts_error;
  logic                     r_ts_type;
  pcie_tsos_t               r_ts_data;
  logic [CNT_W-1:0]         r_count;
  logic                     r_prev_valid;

  logic                     w_is_com;
  logic                     w_sym_ok;
  logic                     w_wr;
  logic [IDX_W-1:0]         w_wr_idx;
  logic                     w_err;
  logic                     w_done;
  pcie_tsos_t               w_new_ts;
  logic                     w_new_type;
  logic                     w_same;

  assign s_axis_tready   = 1'b1;
  assign ts_valid        = r_ts_valid;
  assign ts_error        = r_ts_error;
  assign ts_type         = r_ts_type;
  assign ts_data         = r_ts_data;
  assign ts_consec_count = r_count;

  assign w_is_com = s_axis_tuser && (s_axis_tdata == COM);

  always_comb begin
    w_sym_ok = 1'b0;
    case (r_idx)
      4'd1, 4'd2:       w_sym_ok = !s_axis_tuser || (s_axis_tdata == PAD);
      4'd3, 4'd4, 4'd5: w_sym_ok = !s_axis_tuser;
      4'd6:             w_sym_ok = !s_axis_tuser && ((s_axis_tdata == TS1) || (s_axis_tdata == TS2));
      default:          w_sym_ok = !s_axis_tuser && (s_axis_tdata == r_buf[6]) && (r_idx > 4'd6);
    endcase
  end

  always_comb begin
    w_next_state = r_state;
    w_next_idx   = r_idx;
    w_wr         = 1'b0;
    w_wr_idx     = w_is_com ? '0 : r_idx;
    w_err        = 1'b0;
    w_done       = 1'b0;
    if (s_axis_tvalid) begin
      case (r_state)
        HUNT: begin
          if (w_is_com) begin
            w_wr         = 1'b1;
            w_next_idx   = 4'd1;
            w_next_state = CAPTURE;
          end else begin
            w_next_state = HUNT;
          end
        end
        CAPTURE: begin
          // A COM mid-capture restarts on itself so no symbol is lost
          if (w_is_com) begin
            w_err        = 1'b1;
            w_wr         = 1'b1;
            w_next_idx   = 4'd1;
            w_next_state = CAPTURE;
          end else if (!w_sym_ok) begin
            w_err        = 1'b1;
            w_next_idx   = '0;
            w_next_state = HUNT;
          end else if (r_idx == LAST_IDX) begin
            w_done       = 1'b1;
            w_next_idx   = '0;
            w_next_state = HUNT;
          end else begin
            w_wr         = 1'b1;
            w_next_idx   = r_idx + 4'd1;
          end
        end
        default: begin
          w_next_idx   = '0;
          w_next_state = HUNT;
        end
      endcase
    end else begin
      w_next_state = r_state;
    end
  end

  // The held output TS doubles as the "previous TS" for the identical check
  always_comb begin
    w_new_ts   = {s_axis_tdata, r_buf};
    w_new_type = (r_buf[6] == TS2);
    w_same     = r_prev_valid && (w_new_type == r_ts_type) &&
                 (w_new_ts[1] == r_ts_data[1]) && (w_new_ts[2] == r_ts_data[2]) &&
                 (w_new_ts[4] == r_ts_data[4]) && (w_new_ts[5] == r_ts_data[5]) &&
                 (!MATCH_NFTS || (w_new_ts[3] == r_ts_data[3]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= HUNT;
      r_idx   <= '0;
    end else begin
      r_state <= w_next_state;
      r_idx   <= w_next_idx;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf        <= '0;
      r_ts_valid   <= 1'b0;
      r_ts_error   <= 1'b0;
      r_ts_type    <= 1'b0;
      r_ts_data    <= '0;
      r_count      <= '0;
      r_prev_valid <= 1'b0;
    end else begin
      r_ts_valid <= w_done;
      r_ts_error <= w_err;
      if (w_wr) begin
        r_buf[w_wr_idx] <= s_axis_tdata;
      end
      if (w_done) begin
        r_ts_data    <= w_new_ts;
        r_ts_type    <= w_new_type;
        r_prev_valid <= 1'b1;
        if (clear_count || !w_same) begin
          r_count <= CNT_W'(1);
        end else if (r_count != CNT_MAX) begin
          r_count <= r_count + CNT_W'(1);
        end
      end else if (w_err || clear_count) begin
        r_count      <= '0;
        r_prev_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pcie_tsos_rx.sv
// Directed self-checking bench for pcie_tsos_rx: well-formed TS1/TS2 streams,
// counter saturation, malformed/restarted sets, clear_count and mid-capture reset.
module tb_pcie_tsos_rx;

  logic         clk = 1'b0;
  logic         rst;
  logic [7:0]   s_axis_tdata;
  logic         s_axis_tuser;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         clear_count;
  logic         ts_valid;
  logic         ts_type;
  logic [127:0] ts_data;
  logic [3:0]   ts_consec_count;
  logic         ts_error;

  int n_checks = 0;
  int n_errors = 0;
  int n_valid  = 0;
  int n_err    = 0;
  int va, ea;

  logic [127:0] ta, tb2, tc, td, te, tf, tg;

  always #5 clk = ~clk;

  pcie_tsos_rx #(.CNT_W(4), .MATCH_NFTS(1'b1)) dut (
    .clk             (clk),
    .rst             (rst),
    .s_axis_tdata    (s_axis_tdata),
    .s_axis_tuser    (s_axis_tuser),
    .s_axis_tvalid   (s_axis_tvalid),
    .s_axis_tready   (s_axis_tready),
    .clear_count     (clear_count),
    .ts_valid        (ts_valid),
    .ts_type         (ts_type),
    .ts_data         (ts_data),
    .ts_consec_count (ts_consec_count),
    .ts_error        (ts_error)
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    n_valid += int'(ts_valid);
    n_err   += int'(ts_error);
  endtask

  task automatic idle(input int n);
    s_axis_tvalid = 1'b0;
    repeat (n) tick();
  endtask

  task automatic beat(input logic [7:0] d, input logic k, input logic clr);
    s_axis_tdata  = d;
    s_axis_tuser  = k;
    s_axis_tvalid = 1'b1;
    clear_count   = clr;
    tick();
    s_axis_tvalid = 1'b0;
    clear_count   = 1'b0;
  endtask

  function automatic logic [127:0] mk(input logic [7:0] id, input logic [7:0] link,
                                      input logic [7:0] lane, input logic [7:0] nfts);
    logic [127:0] t;
    t = '0;
    t[7:0]   = 8'hBC;
    t[15:8]  = link;
    t[23:16] = lane;
    t[31:24] = nfts;
    t[39:32] = 8'h06;
    t[47:40] = 8'h00;
    for (int i = 6; i < 16; i++) t[8*i +: 8] = id;
    return t;
  endfunction

  task automatic send(input logic [127:0] ts, input int lo, input int hi,
                      input bit gaps, input bit clr_last);
    logic k;
    for (int i = lo; i <= hi; i++) begin
      if (gaps) idle(int'($urandom_range(0, 2)));
      k = (i == 0) || ((i == 1 || i == 2) && ts[8*i +: 8] == 8'hF7);
      beat(ts[8*i +: 8], k, clr_last && (i == hi));
    end
  endtask

  initial begin
    rst = 1'b1;
    s_axis_tdata = 8'h00;
    s_axis_tuser = 1'b0;
    s_axis_tvalid = 1'b0;
    clear_count = 1'b0;
    idle(2);
    chk("rst_valid", ts_valid, 0);
    chk("rst_error", ts_error, 0);
    chk("rst_type", ts_type, 0);
    chk("rst_data", ts_data, 0);
    chk("rst_count", ts_consec_count, 0);
    chk("tready", s_axis_tready, 1);
    rst = 1'b0;
    idle(1);

    ta  = mk(8'h4A, 8'h00, 8'h03, 8'h1F);
    tb2 = mk(8'h45, 8'hF7, 8'hF7, 8'h1F);
    tc  = mk(8'h4A, 8'h00, 8'h03, 8'h1F);
    td  = mk(8'h4A, 8'h00, 8'h04, 8'h1F);
    te  = mk(8'h4A, 8'h00, 8'h04, 8'h20);
    tg  = mk(8'h4A, 8'h00, 8'h05, 8'h1F);
    tf  = ta;
    tf[87:80] = 8'h45;

    // Single TS1, contiguous
    va = n_valid;
    send(ta, 0, 14, 1'b0, 1'b0);
    chk("t1_no_early_valid", n_valid - va, 0);
    send(ta, 15, 15, 1'b0, 1'b0);
    chk("t1_valid", ts_valid, 1);
    chk("t1_type", ts_type, 0);
    chk("t1_link", ts_data[15:8], 8'h00);
    chk("t1_lane", ts_data[23:16], 8'h03);
    chk("t1_data", ts_data, ta);
    chk("t1_count", ts_consec_count, 1);
    idle(1);
    chk("t1_pulse", ts_valid, 0);
    chk("t1_data_held", ts_data, ta);

    // 20 identical TS2 with gaps: count saturates at 15
    va = n_valid; ea = n_err;
    for (int i = 0; i < 20; i++) begin
      send(tb2, 0, 15, 1'b1, 1'b0);
      chk($sformatf("ts2_count_%0d", i), ts_consec_count, (i + 1 > 15) ? 15 : i + 1);
      chk($sformatf("ts2_type_%0d", i), ts_type, 1);
    end
    chk("ts2_nvalid", n_valid - va, 20);
    chk("ts2_nerr", n_err - ea, 0);

    // 3 identical TS1 then lane change, then n_fts change
    for (int i = 0; i < 3; i++) begin
      send(tc, 0, 15, 1'b0, 1'b0);
      chk($sformatf("seq_count_%0d", i), ts_consec_count, i + 1);
    end
    send(td, 0, 15, 1'b0, 1'b0);
    chk("lane_change_count", ts_consec_count, 1);
    send(te, 0, 15, 1'b0, 1'b0);
    chk("nfts_change_count", ts_consec_count, 1);

    // Bad identifier at idx 10
    va = n_valid; ea = n_err;
    send(tf, 0, 10, 1'b0, 1'b0);
    chk("bad_error_pulse", ts_error, 1);
    chk("bad_count", ts_consec_count, 0);
    send(tf, 11, 15, 1'b0, 1'b0);
    chk("bad_nvalid", n_valid - va, 0);
    chk("bad_nerr", n_err - ea, 1);
    send(ta, 0, 15, 1'b0, 1'b0);
    chk("after_bad_valid", ts_valid, 1);
    chk("after_bad_count", ts_consec_count, 1);

    // COM at idx 8 restarts capture
    send(ta, 0, 7, 1'b0, 1'b0);
    va = n_valid; ea = n_err;
    send(ta, 0, 0, 1'b0, 1'b0);
    chk("com_restart_error", ts_error, 1);
    send(ta, 1, 15, 1'b0, 1'b0);
    chk("com_restart_valid", ts_valid, 1);
    chk("com_restart_count", ts_consec_count, 1);
    chk("com_restart_nerr", n_err - ea, 1);
    chk("com_restart_nvalid", n_valid - va, 1);

    // clear_count coincident with the 4th identical TS update
    for (int i = 0; i < 3; i++) begin
      send(tg, 0, 15, 1'b0, 1'b0);
      chk($sformatf("clr_pre_count_%0d", i), ts_consec_count, i + 1);
    end
    send(tg, 0, 15, 1'b0, 1'b1);
    chk("clr_on_valid_count", ts_consec_count, 1);
    send(tg, 0, 15, 1'b0, 1'b0);
    chk("clr_next_count", ts_consec_count, 2);

    // clear_count alone
    clear_count = 1'b1;
    tick();
    clear_count = 1'b0;
    chk("clr_alone_count", ts_consec_count, 0);
    send(tg, 0, 15, 1'b0, 1'b0);
    chk("clr_alone_next", ts_consec_count, 1);

    // Reset at idx 9
    send(tg, 0, 8, 1'b0, 1'b0);
    rst = 1'b1;
    beat(tg[79:72], 1'b0, 1'b0);
    chk("midrst_valid", ts_valid, 0);
    chk("midrst_error", ts_error, 0);
    chk("midrst_type", ts_type, 0);
    chk("midrst_data", ts_data, 0);
    chk("midrst_count", ts_consec_count, 0);
    rst = 1'b0;
    va = n_valid; ea = n_err;
    send(tg, 10, 15, 1'b0, 1'b0);
    chk("midrst_tail_nvalid", n_valid - va, 0);
    chk("midrst_tail_nerr", n_err - ea, 0);
    send(tg, 0, 15, 1'b0, 1'b0);
    chk("postrst_valid", ts_valid, 1);
    chk("postrst_data", ts_data, tg);
    chk("postrst_count", ts_consec_count, 1);
    idle(2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pcie_tsos_rx.md
Name: pcie_tsos_rx

Overview:
- Per-lane Gen1/Gen2 receive parser for TS1/TS2 training ordered sets.
- Sits downstream of the 8b/10b decoder and symbol aligner. Consumes one decoded symbol per beat with a K flag.
- Captures the 16 symbols into a pcie_tsos_t and validates them. Reports the TS type and fields plus a consecutive-identical-TS count to the LTSSM.
- It is the receive counterpart of the transmit-side TS generation in pcie_phy_pkg.

Parameters:
- CNT_W, 4: width of the consecutive-TS counter; the counter saturates at 2^CNT_W-1.
- MATCH_NFTS, 1: 1 includes symbol 3 (n_fts) in the "identical TS" comparison; 0 excludes it.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous, active-high reset.
- s_axis_tdata  input  8  decoded symbol.
- s_axis_tuser  input  1  K-symbol flag (1 = control symbol).
- s_axis_tvalid  input  1  symbol valid.
- s_axis_tready  output  1  tied to 1; the block never stalls.
- clear_count  input  1  zeroes the consecutive counter and forgets the previous TS.
- ts_valid  output  1  one-cycle pulse: a well-formed TS was received.
- ts_type  output  1  0 = TS1 (8'h4A), 1 = TS2 (8'h45); held until the next ts_valid.
- ts_data  output  128  captured pcie_tsos_t; symbol n occupies bits [8n+7:8n]; held until the next ts_valid.
- ts_consec_count  output  CNT_W  number of consecutive identical TSs, including the current one.
- ts_error  output  1  one-cycle pulse: malformed TS was aborted.

Behaviour:
- Reset values:
  - ts_valid, ts_error, ts_type, ts_data, ts_consec_count = 0.
  - Previous-TS-valid flag = 0.
  - FSM = HUNT, index = 0.
- A beat is accepted when s_axis_tvalid = 1. With tvalid = 0 all state holds; gaps of any length are legal.
- FSM states:
  - HUNT: wait for COM (K=1, 8'hBC). On COM, store symbol 0, set index = 1, go to CAPTURE. All other symbols are ignored, with no error.
  - CAPTURE: store the accepted symbol at the current index and increment index.
- Per-index checks in CAPTURE (any failure: pulse ts_error, discard the TS, return to HUNT):
  - idx 1, 2 (link, lane): either K=1 and 8'hF7 (PAD), or K=0 with any value.
  - idx 3..5: K must be 0.
  - idx 6: K=0 and value must be 8'h4A or 8'h45. This value latches the tentative type.
  - idx 7..15: K=0 and value must equal the symbol at idx 6.
- COM received in CAPTURE at idx 1..15:
  - Pulse ts_error.
  - Restart capture with this COM as symbol 0 (index = 1, stay in CAPTURE). No symbol is lost.
- After idx 15 is accepted and passes its check:
  - On the next cycle, ts_valid = 1 and ts_data / ts_type update. Latency is 1 cycle after the last symbol.
  - FSM returns to HUNT on that same acceptance, so a back-to-back COM on the next beat is captured.
- Consecutive counter, updated on the same cycle as ts_valid:
  - "Identical" means: previous flag = 1, same ts_type, and symbols 1, 2, 4, 5 equal the previous TS. Symbol 3 is also compared when MATCH_NFTS = 1.
  - If identical: count = min(count+1, 2^CNT_W-1).
  - If not identical: count = 1.
  - In both cases, store this TS as the previous TS and set previous flag = 1.
  - On ts_error: count = 0 and previous flag = 0.
- clear_count:
  - Alone: count = 0, previous flag = 0.
  - Same cycle as a ts_valid update: count = 1 and that TS becomes the new previous TS. The clear applies first.
- Reset mid-capture: the partial TS is discarded. No ts_valid or ts_error is generated.

Decomposition:
- In pcie_phy_pkg:
  - Reuse pcie_tsos_t, train_seq_e (TS1, TS2) and phy_layer_special_symbols_e (COM, PAD).
  - Add constant TSOS_LEN = 16.
  - Add enum tsos_rx_state_e {HUNT, CAPTURE}.
- Single module; no sub-module is needed. The comparison against the previous TS is inline combinational logic.

Test Plan:
- Feed gen_tsos(TS1, link=8'h00, lane=8'h03, gen2) as 16 contiguous beats → ts_valid one cycle after beat 15; ts_type = 0; ts_data[15:8] = 00, ts_data[23:16] = 03; count = 1.
- Send 20 identical TS2 with PAD link/lane, with random tvalid gaps → ts_valid ×20; ts_type = 1; count steps 1..15 and then holds at 15 (CNT_W = 4).
- Send 3 identical TS1, then a TS1 with lane 03→04 → counts 1, 2, 3, then 1.
- Send a TS1 whose idx 10 is 8'h45 → ts_error pulse, no ts_valid, count = 0. A following valid TS gives count = 1.
- Inject COM at idx 8, then a full TS1 from that COM → one ts_error, then ts_valid for the restarted TS.
- Assert clear_count on the ts_valid update cycle of the 4th identical TS → count = 1. The next identical TS gives count = 2.
- Assert rst at idx 9 → all outputs 0; the remaining symbols are ignored until the next COM.
